// File: rtl/ppu_vram_arbiter.sv
// PPU video-bus arbiter: render fetches and CPU PPUDATA accesses share VRAM using fixed 2-cycle transactions.
// Optional starvation guard for the CPU slot is built only when PPU_VRAM_ARB_STARVE_EN is defined.
module ppu_vram_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_rnd_req,
    input  logic [ADDR_WIDTH-1:0] i_rnd_addr,
    output logic                  o_rnd_ack,
    output logic                  o_rnd_valid,
    output logic [DATA_WIDTH-1:0] o_rnd_data,
    input  logic                  i_cpu_strobe,
    input  logic                  i_cpu_we,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    output logic                  o_cpu_busy,
    output logic                  o_cpu_done,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    output logic                  o_cpu_overrun,
    output logic                  o_video_rd_n,
    output logic                  o_video_we_n,
    output logic [ADDR_WIDTH-1:0] o_video_address,
    output logic [DATA_WIDTH-1:0] o_video_data,
    input  logic [DATA_WIDTH-1:0] i_video_data,
    output logic [1:0]            o_dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  slot_full_q, slot_full_d;
    logic                  slot_we_q, slot_we_d;
    logic [ADDR_WIDTH-1:0] slot_addr_q, slot_addr_d;
    logic [DATA_WIDTH-1:0] slot_wdata_q, slot_wdata_d;
    logic                  own_cpu_q, own_cpu_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rd_n_q, rd_n_d;
    logic                  we_n_q, we_n_d;
    logic [DATA_WIDTH-1:0] vdata_q, vdata_d;
    logic                  rnd_ack_q, rnd_ack_d;
    logic                  rnd_valid_q, rnd_valid_d;
    logic [DATA_WIDTH-1:0] rnd_data_q, rnd_data_d;
    logic                  cpu_done_q, cpu_done_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                  overrun_q, overrun_d;

    logic arb_point;
    logic cpu_win;
    logic rnd_win;
    logic end_data;
    logic starve_hit;

`ifdef PPU_VRAM_ARB_STARVE_EN
    localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);
    logic [7:0] starve_cnt_q, starve_cnt_d;

    assign starve_hit = (starve_cnt_q >= STARVE_LIM8);

    // Counts cycles a captured CPU access sits ungranted; saturates rather than wrapping.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!slot_full_q || cpu_win) begin
            starve_cnt_d = 8'd0;
        end else if (starve_cnt_q != 8'hFF) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            starve_cnt_q <= 8'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic starve_unused;
    assign starve_unused = (STARVE_LIMIT > 0);
    assign starve_hit    = 1'b0;
`endif

    always_comb begin
        arb_point = (state_q == ST_IDLE) || (state_q == ST_DATA);
        cpu_win   = arb_point && slot_full_q && (!i_rnd_req || starve_hit);
        rnd_win   = arb_point && i_rnd_req && !cpu_win;
        end_data  = (state_q == ST_DATA);

        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = (cpu_win || rnd_win) ? ST_ADDR : ST_IDLE;
            ST_ADDR: state_d = ST_DATA;
            ST_DATA: state_d = (cpu_win || rnd_win) ? ST_ADDR : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        own_cpu_d = own_cpu_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if (cpu_win) begin
            own_cpu_d = 1'b1;
            we_d      = slot_we_q;
            addr_d    = slot_addr_q;
            wdata_d   = slot_wdata_q;
        end else if (rnd_win) begin
            own_cpu_d = 1'b0;
            we_d      = 1'b0;
            addr_d    = i_rnd_addr;
            wdata_d   = '0;
        end

        // Bus strobes are registered so they change cleanly with the state they describe.
        rd_n_d  = !((state_d != ST_IDLE) && !we_d);
        we_n_d  = !((state_d != ST_IDLE) && we_d);
        vdata_d = ((state_d != ST_IDLE) && we_d) ? wdata_d : '0;

        rnd_ack_d   = rnd_win;
        rnd_valid_d = end_data && !own_cpu_q;
        rnd_data_d  = rnd_valid_d ? i_video_data : rnd_data_q;
        cpu_done_d  = end_data && own_cpu_q;
        cpu_rdata_d = (cpu_done_d && !we_q) ? i_video_data : cpu_rdata_q;

        // A strobe landing in the same cycle the slot is granted refills it instead of being dropped.
        slot_full_d  = slot_full_q && !cpu_win;
        slot_we_d    = slot_we_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        overrun_d    = 1'b0;
        if (i_cpu_strobe) begin
            if (!slot_full_d) begin
                slot_full_d  = 1'b1;
                slot_we_d    = i_cpu_we;
                slot_addr_d  = i_cpu_addr;
                slot_wdata_d = i_cpu_wdata;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            slot_full_q  <= 1'b0;
            slot_we_q    <= 1'b0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            own_cpu_q    <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            vdata_q      <= '0;
            rnd_ack_q    <= 1'b0;
            rnd_valid_q  <= 1'b0;
            rnd_data_q   <= '0;
            cpu_done_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_full_q  <= slot_full_d;
            slot_we_q    <= slot_we_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            own_cpu_q    <= own_cpu_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_n_q       <= rd_n_d;
            we_n_q       <= we_n_d;
            vdata_q      <= vdata_d;
            rnd_ack_q    <= rnd_ack_d;
            rnd_valid_q  <= rnd_valid_d;
            rnd_data_q   <= rnd_data_d;
            cpu_done_q   <= cpu_done_d;
            cpu_rdata_q  <= cpu_rdata_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_rnd_ack       = rnd_ack_q;
    assign o_rnd_valid     = rnd_valid_q;
    assign o_rnd_data      = rnd_data_q;
    assign o_cpu_done      = cpu_done_q;
    assign o_cpu_rdata     = cpu_rdata_q;
    assign o_cpu_overrun   = overrun_q;
    assign o_cpu_busy      = slot_full_q || ((state_q != ST_IDLE) && own_cpu_q) || cpu_done_q;
    assign o_video_rd_n    = rd_n_q;
    assign o_video_we_n    = we_n_q;
    assign o_video_address = addr_q;
    assign o_video_data    = vdata_q;
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed bench for ppu_vram_arbiter: bus timing checked per cycle, read data checked through expected queues.
module tb_ppu_vram_arbiter;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_rnd_req;
    logic [13:0] i_rnd_addr;
    logic        o_rnd_ack;
    logic        o_rnd_valid;
    logic [7:0]  o_rnd_data;
    logic        i_cpu_strobe;
    logic        i_cpu_we;
    logic [13:0] i_cpu_addr;
    logic [7:0]  i_cpu_wdata;
    logic        o_cpu_busy;
    logic        o_cpu_done;
    logic [7:0]  o_cpu_rdata;
    logic        o_cpu_overrun;
    logic        o_video_rd_n;
    logic        o_video_we_n;
    logic [13:0] o_video_address;
    logic [7:0]  o_video_data;
    logic [7:0]  i_video_data;
    logic [1:0]  o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rnd_exp_q[$];
    logic [8:0] cpu_exp_q[$];

    ppu_vram_arbiter #(
        .ADDR_WIDTH  (14),
        .DATA_WIDTH  (8),
        .STARVE_LIMIT(4)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_rnd_req      (i_rnd_req),
        .i_rnd_addr     (i_rnd_addr),
        .o_rnd_ack      (o_rnd_ack),
        .o_rnd_valid    (o_rnd_valid),
        .o_rnd_data     (o_rnd_data),
        .i_cpu_strobe   (i_cpu_strobe),
        .i_cpu_we       (i_cpu_we),
        .i_cpu_addr     (i_cpu_addr),
        .i_cpu_wdata    (i_cpu_wdata),
        .o_cpu_busy     (o_cpu_busy),
        .o_cpu_done     (o_cpu_done),
        .o_cpu_rdata    (o_cpu_rdata),
        .o_cpu_overrun  (o_cpu_overrun),
        .o_video_rd_n   (o_video_rd_n),
        .o_video_we_n   (o_video_we_n),
        .o_video_address(o_video_address),
        .o_video_data   (o_video_data),
        .i_video_data   (i_video_data),
        .o_dbg_state    (o_dbg_state)
    );

    // Clock and VRAM model: read data depends on the address so wrong addresses show up as wrong data.
    initial i_clk = 1'b1;
    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] vram_f(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'hB9;
    endfunction

    assign i_video_data = vram_f(o_video_address);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // State updates on the falling edge, so the rising edge is mid-cycle.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic strobe_cpu(input logic we, input logic [13:0] addr, input logic [7:0] wdata);
        i_cpu_strobe = 1'b1;
        i_cpu_we     = we;
        i_cpu_addr   = addr;
        i_cpu_wdata  = wdata;
        if (we) cpu_exp_q.push_back({1'b0, 8'h00});
        else    cpu_exp_q.push_back({1'b1, vram_f(addr)});
    endtask

    // Scoreboard: every completion pops the oldest expectation.
    always @(posedge i_clk) begin
        #1;
        if (o_rnd_valid) begin
            chk("rnd_valid_expected", 32'(rnd_exp_q.size() != 0), 32'd1);
            if (rnd_exp_q.size() != 0) chk("rnd_data", 32'(o_rnd_data), 32'(rnd_exp_q.pop_front()));
        end
        if (o_cpu_done) begin
            chk("cpu_done_expected", 32'(cpu_exp_q.size() != 0), 32'd1);
            if (cpu_exp_q.size() != 0) begin
                logic [8:0] e;
                e = cpu_exp_q.pop_front();
                if (e[8]) chk("cpu_rdata", 32'(o_cpu_rdata), 32'(e[7:0]));
            end
        end
    end

    initial begin
        int acks;
        int cpu_seen;
        int first_cpu;

        i_reset_n    = 1'b0;
        i_rnd_req    = 1'b0;
        i_rnd_addr   = '0;
        i_cpu_strobe = 1'b0;
        i_cpu_we     = 1'b0;
        i_cpu_addr   = '0;
        i_cpu_wdata  = '0;
        repeat (3) step();
        chk("rst_rd_n",    32'(o_video_rd_n), 32'd1);
        chk("rst_we_n",    32'(o_video_we_n), 32'd1);
        chk("rst_addr",    32'(o_video_address), 32'd0);
        chk("rst_vdata",   32'(o_video_data), 32'd0);
        chk("rst_rnd_data", 32'(o_rnd_data), 32'd0);
        chk("rst_cpu_rdata", 32'(o_cpu_rdata), 32'd0);
        chk("rst_pulses",  32'({o_rnd_ack, o_rnd_valid, o_cpu_done, o_cpu_overrun}), 32'd0);
        chk("rst_busy",    32'(o_cpu_busy), 32'd0);
        chk("rst_state",   32'(o_dbg_state), 32'd0);
        i_reset_n = 1'b1;
        step();
        step();

        // CPU write while idle.
        strobe_cpu(1'b1, 14'h2005, 8'hA7);
        step();
        i_cpu_strobe = 1'b0;
        chk("t1_busy_pend", 32'(o_cpu_busy), 32'd1);
        chk("t1_we_n_pend", 32'(o_video_we_n), 32'd1);
        step();
        chk("t1_addr",   32'(o_video_address), 32'h2005);
        chk("t1_we_n_a", 32'(o_video_we_n), 32'd0);
        chk("t1_rd_n_a", 32'(o_video_rd_n), 32'd1);
        chk("t1_vdata_a", 32'(o_video_data), 32'hA7);
        chk("t1_state_a", 32'(o_dbg_state), 32'd1);
        step();
        chk("t1_we_n_d",  32'(o_video_we_n), 32'd0);
        chk("t1_vdata_d", 32'(o_video_data), 32'hA7);
        chk("t1_state_d", 32'(o_dbg_state), 32'd2);
        step();
        chk("t1_done",    32'(o_cpu_done), 32'd1);
        chk("t1_we_n_end", 32'(o_video_we_n), 32'd1);
        chk("t1_vdata_end", 32'(o_video_data), 32'd0);
        step();
        chk("t1_done_off", 32'(o_cpu_done), 32'd0);
        chk("t1_busy_off", 32'(o_cpu_busy), 32'd0);

        // Render read with fixed latency.
        i_rnd_req  = 1'b1;
        i_rnd_addr = 14'h23C0;
        rnd_exp_q.push_back(8'h5A);
        step();
        chk("t2_ack",    32'(o_rnd_ack), 32'd1);
        chk("t2_rd_n_a", 32'(o_video_rd_n), 32'd0);
        chk("t2_addr",   32'(o_video_address), 32'h23C0);
        i_rnd_req = 1'b0;
        step();
        chk("t2_ack_off", 32'(o_rnd_ack), 32'd0);
        chk("t2_rd_n_d",  32'(o_video_rd_n), 32'd0);
        chk("t2_valid_early", 32'(o_rnd_valid), 32'd0);
        step();
        chk("t2_valid",  32'(o_rnd_valid), 32'd1);
        chk("t2_data",   32'(o_rnd_data), 32'h5A);
        chk("t2_rd_n_end", 32'(o_video_rd_n), 32'd1);
        step();
        chk("t2_valid_off", 32'(o_rnd_valid), 32'd0);

        // Render and CPU read together: render first, CPU follows with no gap.
        i_rnd_req  = 1'b1;
        i_rnd_addr = 14'h0123;
        rnd_exp_q.push_back(vram_f(14'h0123));
        strobe_cpu(1'b0, 14'h3000, 8'h00);
        step();
        chk("t3_ack",  32'(o_rnd_ack), 32'd1);
        chk("t3_addr_r", 32'(o_video_address), 32'h0123);
        chk("t3_busy", 32'(o_cpu_busy), 32'd1);
        i_rnd_req    = 1'b0;
        i_cpu_strobe = 1'b0;
        step();
        chk("t3_rd_n_rd", 32'(o_video_rd_n), 32'd0);
        step();
        chk("t3_addr_c", 32'(o_video_address), 32'h3000);
        chk("t3_rd_n_c", 32'(o_video_rd_n), 32'd0);
        chk("t3_ack_c",  32'(o_rnd_ack), 32'd0);
        chk("t3_state_c", 32'(o_dbg_state), 32'd1);
        step();
        chk("t3_state_cd", 32'(o_dbg_state), 32'd2);
        step();
        chk("t3_done",  32'(o_cpu_done), 32'd1);
        chk("t3_rdata", 32'(o_cpu_rdata), 32'(vram_f(14'h3000)));
        step();

        // Second strobe while slot is full is dropped with one overrun pulse.
        i_rnd_req  = 1'b1;
        i_rnd_addr = 14'h0400;
        rnd_exp_q.push_back(vram_f(14'h0400));
        step();
        strobe_cpu(1'b1, 14'h2100, 8'h3C);
        step();
        chk("t4_ovr_first", 32'(o_cpu_overrun), 32'd0);
        i_cpu_strobe = 1'b1;
        i_cpu_we     = 1'b0;
        i_cpu_addr   = 14'h2200;
        rnd_exp_q.push_back(vram_f(14'h0400));
        step();
        chk("t4_ovr",   32'(o_cpu_overrun), 32'd1);
        chk("t4_ack2",  32'(o_rnd_ack), 32'd1);
        chk("t4_addr_r", 32'(o_video_address), 32'h0400);
        i_cpu_strobe = 1'b0;
        i_rnd_req    = 1'b0;
        step();
        chk("t4_ovr_off", 32'(o_cpu_overrun), 32'd0);
        step();
        chk("t4_addr_c", 32'(o_video_address), 32'h2100);
        chk("t4_we_n",   32'(o_video_we_n), 32'd0);
        chk("t4_vdata",  32'(o_video_data), 32'h3C);
        step();
        step();
        chk("t4_done", 32'(o_cpu_done), 32'd1);
        step();
        chk("t4_busy_off", 32'(o_cpu_busy), 32'd0);

        // Continuous render with a pending CPU write.
        i_rnd_req  = 1'b1;
        i_rnd_addr = 14'h0800;
        strobe_cpu(1'b1, 14'h2300, 8'h11);
        acks      = 0;
        cpu_seen  = 0;
        first_cpu = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 1) i_cpu_strobe = 1'b0;
            if (o_rnd_ack) begin
                acks++;
                rnd_exp_q.push_back(vram_f(14'h0800));
            end
            if (!o_video_we_n && cpu_seen == 0) begin
                cpu_seen  = 1;
                first_cpu = i;
            end
        end
        i_rnd_req = 1'b0;
`ifdef PPU_VRAM_ARB_STARVE_EN
        chk("t5_cpu_granted", 32'(cpu_seen), 32'd1);
        chk("t5_grant_bound", 32'(first_cpu >= 1 && first_cpu <= 7), 32'd1);
`else
        chk("t5_cpu_starved", 32'(cpu_seen), 32'd0);
        chk("t5_render_acks", 32'(acks), 32'd20);
        chk("t5_busy_held",   32'(o_cpu_busy), 32'd1);
`endif
        repeat (8) step();
        chk("t5_busy_drain", 32'(o_cpu_busy), 32'd0);

        // Reset during ADDR of a CPU write aborts it with no completion.
        i_cpu_strobe = 1'b1;
        i_cpu_we     = 1'b1;
        i_cpu_addr   = 14'h2400;
        i_cpu_wdata  = 8'h55;
        step();
        i_cpu_strobe = 1'b0;
        step();
        chk("t6_we_n_before", 32'(o_video_we_n), 32'd0);
        i_reset_n = 1'b0;
        #1;
        chk("t6_we_n_reset", 32'(o_video_we_n), 32'd1);
        chk("t6_busy_reset", 32'(o_cpu_busy), 32'd0);
        chk("t6_state_reset", 32'(o_dbg_state), 32'd0);
        step();
        step();
        i_reset_n = 1'b1;
        step();
        chk("t6_no_done",  32'(o_cpu_done), 32'd0);
        chk("t6_rdata_rst", 32'(o_cpu_rdata), 32'd0);
        strobe_cpu(1'b1, 14'h2401, 8'h66);
        step();
        i_cpu_strobe = 1'b0;
        step();
        chk("t6_addr2",  32'(o_video_address), 32'h2401);
        chk("t6_we_n2",  32'(o_video_we_n), 32'd0);
        chk("t6_vdata2", 32'(o_video_data), 32'h66);
        step();
        step();
        chk("t6_done2", 32'(o_cpu_done), 32'd1);
        step();
        chk("t6_busy2", 32'(o_cpu_busy), 32'd0);

        repeat (4) step();
        chk("rnd_queue_empty", 32'(rnd_exp_q.size()), 32'd0);
        chk("cpu_queue_empty", 32'(cpu_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
